// File: rtl/counter_timer_arbiter.sv
// Round-robin arbiter sharing one N-bit interval counter among R requesters; done pulses lim+1 cycles after grant.
// Define COUNTER_ARB_FIXED_PRIO_EN to freeze the priority pointer at 0 (lowest index always wins).
module counter_timer_arbiter #(
  parameter int N = 6,
  parameter int R = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [R-1:0]   req,
  input  logic [R*N-1:0] limit_flat,
  output logic [R-1:0]   gnt,
  output logic [R-1:0]   done,
  output logic [N-1:0]   count,
  output logic           busy
);
  localparam int IW = $clog2(R);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] sel_q, sel_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  lim_q, lim_d;
  logic [N-1:0]  count_q, count_d;
  logic [IW-1:0] pick;
  logic          found;
  logic [IW-1:0] ptr_adv;

  always_comb begin : arb
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < R; k++) begin
      if (!found && req[(int'(ptr_q) + k) % R]) begin
        pick  = IW'((int'(ptr_q) + k) % R);
        found = 1'b1;
      end
    end
  end

  // Pointer moves just past the requester that finished or gave up the counter.
`ifdef COUNTER_ARB_FIXED_PRIO_EN
  assign ptr_adv = '0;
`else
  assign ptr_adv = (sel_q == IW'(R - 1)) ? '0 : sel_q + 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      lim_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      lim_q   <= lim_d;
      count_q <= count_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    sel_d   = sel_q;
    lim_d   = lim_q;
    count_d = count_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_RUN;
          sel_d   = pick;
          lim_d   = limit_flat[int'(pick)*N +: N];
          count_d = '0;
        end
      end
      S_RUN: begin
        // Abort takes precedence over reaching the limit.
        if (!req[sel_q]) begin
          state_d = S_IDLE;
          count_d = '0;
          ptr_d   = ptr_adv;
        end else if (count_q == lim_q) begin
          state_d = S_DONE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        count_d = '0;
        ptr_d   = ptr_adv;
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_comb begin : outputs
    gnt  = '0;
    done = '0;
    busy = 1'b0;
    if (state_q != S_IDLE) begin
      gnt[sel_q] = 1'b1;
      busy       = 1'b1;
    end
    if (state_q == S_DONE) begin
      done[sel_q] = 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_counter_timer_arbiter.sv
// Bench for counter_timer_arbiter: directed literal checks plus randomized traffic against a transaction-level model.
module tb_counter_timer_arbiter;
  localparam int N = 6;
  localparam int R = 4;

  logic           clock;
  logic           reset;
  logic [R-1:0]   req;
  logic [R*N-1:0] limit_flat;
  logic [R-1:0]   gnt;
  logic [R-1:0]   done;
  logic [N-1:0]   count;
  logic           busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model: owner of the counter (-1 = idle) and cycles elapsed since its grant.
  int m_owner   = -1;
  int m_elapsed = 0;
  int m_lim     = 0;
  int m_ptr     = 0;

  counter_timer_arbiter #(.N(N), .R(R)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .limit_flat (limit_flat),
    .gnt        (gnt),
    .done       (done),
    .count      (count),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [R-1:0] e_gnt();
    logic [R-1:0] v;
    v = '0;
    if (m_owner >= 0) v[m_owner] = 1'b1;
    return v;
  endfunction

  function automatic logic [R-1:0] e_done();
    logic [R-1:0] v;
    v = '0;
    if (m_owner >= 0 && m_elapsed == m_lim + 1) v[m_owner] = 1'b1;
    return v;
  endfunction

  function automatic logic [N-1:0] e_count();
    if (m_owner < 0) return '0;
    return (m_elapsed > m_lim) ? N'(m_lim) : N'(m_elapsed);
  endfunction

  function automatic logic e_busy();
    return (m_owner >= 0);
  endfunction

  // One clock edge of the model, from inputs held stable since the previous falling edge.
  task automatic model_step();
    if (reset) begin
      m_owner   = -1;
      m_elapsed = 0;
      m_ptr     = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < R; k++) begin
        int i;
        i = (m_ptr + k) % R;
        if (m_owner < 0 && req[i]) begin
          m_owner   = i;
          m_elapsed = 0;
          m_lim     = int'(limit_flat[i*N +: N]);
        end
      end
    end else if (m_elapsed == m_lim + 1 || !req[m_owner]) begin
`ifdef COUNTER_ARB_FIXED_PRIO_EN
      m_ptr = 0;
`else
      m_ptr = (m_owner + 1) % R;
`endif
      m_owner   = -1;
      m_elapsed = 0;
    end else begin
      m_elapsed++;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("cyc_gnt",   64'(gnt),   64'(e_gnt()));
      chk("cyc_done",  64'(done),  64'(e_done()));
      chk("cyc_count", 64'(count), 64'(e_count()));
      chk("cyc_busy",  64'(busy),  64'(e_busy()));
    end
  end

  initial begin
    logic [R-1:0] exp_ord [5];
`ifdef COUNTER_ARB_FIXED_PRIO_EN
    exp_ord[0] = 4'b0001; exp_ord[1] = 4'b0001; exp_ord[2] = 4'b0001;
    exp_ord[3] = 4'b0001; exp_ord[4] = 4'b0001;
`else
    exp_ord[0] = 4'b0001; exp_ord[1] = 4'b0010; exp_ord[2] = 4'b0100;
    exp_ord[3] = 4'b1000; exp_ord[4] = 4'b0001;
`endif
    reset = 1'b1;
    req   = 4'b1111;
    for (int i = 0; i < R; i++) limit_flat[i*N +: N] = N'(1);
    chk_en = 1'b1;

    // Reset held with all requests pending
    tick();
    tick();
    chk("rst_gnt",   64'(gnt),   64'(0));
    chk("rst_done",  64'(done),  64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_busy",  64'(busy),  64'(0));
    reset = 1'b0;
    tick();
    chk("rst_rel_gnt", 64'(gnt), 64'(4'b0001));

    // Single interval, limit 3
    reset = 1'b1; req = '0;
    tick();
    reset = 1'b0;
    tick();
    req = 4'b0001;
    limit_flat[0 +: N] = N'(3);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("l3_gnt",   64'(gnt),   64'(4'b0001));
      chk("l3_count", 64'(count), 64'(c));
      chk("l3_model_count", 64'(e_count()), 64'(c));
      chk("l3_nodone", 64'(done), 64'(0));
    end
    tick();
    chk("l3_done",       64'(done),     64'(4'b0001));
    chk("l3_model_done", 64'(e_done()), 64'(4'b0001));
    chk("l3_done_count", 64'(count),    64'(3));
    req = '0;
    tick();
    chk("l3_end_gnt",   64'(gnt),   64'(0));
    chk("l3_end_count", 64'(count), 64'(0));
    chk("l3_end_done",  64'(done),  64'(0));

    // Grant order with all requests held
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < R; i++) limit_flat[i*N +: N] = N'(1);
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 20; c++) begin
        tick();
        if (gnt != '0) break;
      end
      chk("rr_order", 64'(gnt), 64'(exp_ord[g]));
      for (int c = 0; c < 20; c++) begin
        tick();
        if (gnt == '0) break;
      end
      chk("rr_release", 64'(gnt), 64'(0));
    end

    // Limit 0: one RUN cycle
    req = 4'b0100;
    limit_flat[2*N +: N] = N'(0);
    tick();
    chk("l0_gnt",   64'(gnt),   64'(4'b0100));
    chk("l0_count", 64'(count), 64'(0));
    tick();
    chk("l0_done",  64'(done),  64'(4'b0100));
    chk("l0_model_done", 64'(e_done()), 64'(4'b0100));
    req = '0;
    tick();
    chk("l0_end", 64'(gnt), 64'(0));

    // Maximum limit, limit changed after grant
    req = 4'b0100;
    limit_flat[2*N +: N] = N'(63);
    tick();
    chk("l63_gnt", 64'(gnt), 64'(4'b0100));
    limit_flat[2*N +: N] = N'(5);
    repeat (63) tick();
    chk("l63_count", 64'(count), 64'(63));
    tick();
    chk("l63_done",       64'(done),  64'(4'b0100));
    chk("l63_done_count", 64'(count), 64'(63));
    req = '0;
    tick();
    chk("l63_end_count", 64'(count), 64'(0));

    // Abort at count 4
    req = 4'b0010;
    limit_flat[1*N +: N] = N'(10);
    tick();
    chk("ab_gnt", 64'(gnt), 64'(4'b0010));
    repeat (4) tick();
    chk("ab_count4", 64'(count), 64'(4));
    req = 4'b1101;
    tick();
    chk("ab_gnt0",  64'(gnt),   64'(0));
    chk("ab_cnt0",  64'(count), 64'(0));
    chk("ab_done0", 64'(done),  64'(0));
    chk("ab_busy0", 64'(busy),  64'(0));
    tick();
`ifdef COUNTER_ARB_FIXED_PRIO_EN
    chk("ab_next", 64'(gnt), 64'(4'b0001));
`else
    chk("ab_next", 64'(gnt), 64'(4'b0100));
`endif
    req = '0;
    tick();
    chk("ab_idle", 64'(gnt), 64'(0));

    // Reset mid-run restores pointer to 0
    req = 4'b0001;
    limit_flat[0 +: N] = N'(10);
    tick();
    repeat (5) tick();
    chk("mr_count5", 64'(count), 64'(5));
    reset = 1'b1;
    tick();
    chk("mr_count", 64'(count), 64'(0));
    chk("mr_gnt",   64'(gnt),   64'(0));
    chk("mr_busy",  64'(busy),  64'(0));
    chk("mr_done",  64'(done),  64'(0));
    tick();
    chk("mr_done2", 64'(done),  64'(0));
    reset = 1'b0;
    req = 4'b1010;
    tick();
    chk("mr_ptr0", 64'(gnt), 64'(4'b0010));
    req = '0;
    tick();

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < R; i++) begin
        if ($urandom_range(0, 15) == 0) req[i] = ~req[i];
        if ($urandom_range(0, 9) == 0) limit_flat[i*N +: N] = N'(63);
        else limit_flat[i*N +: N] = N'($urandom_range(0, 6));
      end
      tick();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_timer_arbiter.md
Name: counter_timer_arbiter

Overview:
- Shares one N-bit up-counter among R requesters; each requester asks for a timed interval of `limit` cycles.
- A round-robin arbiter grants the counter to one requester at a time. The FSM clears the counter, counts up to the latched limit, then pulses done to the grantee.
- Sits between client FSMs in the lab designs and the shared counter datapath, which is built inside this block.

Parameters:
- N, 6, counter/limit width in bits (N >= 2).
- R, 4, number of requesters (2..8).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  R  per-requester request level; held high until done or abort.
- limit_flat  in  R*N  requester i's limit at bits [i*N +: N]; sampled only at grant.
- gnt  out  R  one-hot grant; all-zero when idle.
- done  out  R  one-cycle pulse to the grantee when its interval completes.
- count  out  N  current value of the shared counter.
- busy  out  1  high while any grant is active.

Behaviour:
- Reset values (synchronous, active-high; overrides all other activity in the same cycle):
  - state = IDLE; gnt = 0, done = 0, count = 0, busy = 0.
  - Priority pointer ptr = 0, so requester 0 has highest priority.
- IDLE:
  - If req != 0, select the first asserted req scanning ptr, ptr+1, ... mod R.
  - Next edge: state = RUN, gnt = onehot(sel), busy = 1, count = 0, lim_q = limit slice of sel.
  - If req == 0, stay in IDLE with all outputs 0.
- RUN:
  - If req[sel] = 0, abort. Next edge: IDLE, gnt = 0, busy = 0, count = 0, no done pulse, ptr = (sel+1) mod R.
  - Else if count == lim_q: next edge enters DONE; count holds.
  - Else: count = count + 1.
- DONE (one cycle):
  - done[sel] = 1; gnt and busy stay asserted; count = lim_q.
  - Next edge: IDLE, gnt = 0, done = 0, busy = 0, count = 0, ptr = (sel+1) mod R.
- Timing:
  - limit = 0: RUN lasts 1 cycle. Latency from gnt rising to the done pulse is lim_q+1 cycles.
  - Minimum one IDLE cycle between consecutive grants.
  - count never exceeds lim_q, so it never wraps; limit = 2^N-1 is legal.
- Changes to limit_flat after grant are ignored.
- Changes to other requesters' req during RUN/DONE are ignored until the next IDLE.
- A requester still holding req after its done pulse is re-eligible, but behind all others because ptr has advanced past it.
- At most one bit of gnt and of done is ever high.
- done is only high while the matching gnt bit is high.

Optional Feature:
- Macro: COUNTER_ARB_FIXED_PRIO_EN.
- When defined: ptr is held at 0 permanently and never advances; the lowest-index asserted req always wins. Everything else is unchanged.
- When undefined: round-robin behaviour as specified above.

Test Plan:
- Reset with req = 4'b1111 held → gnt = 0, done = 0, count = 0, busy = 0 for the cycle after reset. After reset releases, gnt = 4'b0001 one cycle later.
- req = 4'b0001, limit0 = 3:
  - count sequence 0,1,2,3 during RUN.
  - done = 4'b0001 for exactly one cycle, 4 cycles after gnt rises.
  - Then gnt = 0 and count = 0.
- req = 4'b1111 held, all limits = 1:
  - Grant order is 0,1,2,3,0 (round-robin).
  - With COUNTER_ARB_FIXED_PRIO_EN defined, every grant goes to requester 0.
- req = 4'b0100, limit2 = 0 → RUN is 1 cycle at count = 0, then done = 4'b0100. limit2 = 63 → count reaches 63 without wrap, then done pulses.
- Abort: requester 1 granted with limit = 10; drop req[1] at count = 4 → next cycle IDLE, count = 0, done stays 0, next grant goes to requester 2 or later.
- Reset mid-run: assert reset at count = 5 → next edge count = 0, gnt = 0, busy = 0, ptr = 0, and no done pulse.
